// File: rtl/glbl_arb_pkg.sv
// Shared types and defaults for the two-master global register bus arbiter.
package glbl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_0BAD;
  localparam int unsigned TMO_CYC_DEF  = 255;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } arb_req_t;

  function automatic arb_req_t make_req(input logic        wr,
                                        input logic [7:0]  addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  be);
    arb_req_t r;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.be    = be;
    return r;
  endfunction

endpackage

// File: rtl/glbl_arb_tmo.sv
// 8-bit clearable access timeout counter; expired_o flags the last allowed BUSY cycle.
module glbl_arb_tmo
  import glbl_arb_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(TMO_CYC - 1));

endmodule

// File: rtl/glbl_reg_arb.sv
// Round-robin arbiter for two masters on the global register bus, one access in
// flight, with a per-access timeout that completes the access with an error.
module glbl_reg_arb
  import glbl_arb_pkg::*;
#(
  parameter int unsigned TMO_CYC  = TMO_CYC_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        rq0_cs,
  input  logic        rq0_wr,
  input  logic [7:0]  rq0_addr,
  input  logic [31:0] rq0_wdata,
  input  logic [3:0]  rq0_be,
  output logic [31:0] rq0_rdata,
  output logic        rq0_ack,
  output logic        rq0_err,
  input  logic        rq1_cs,
  input  logic        rq1_wr,
  input  logic [7:0]  rq1_addr,
  input  logic [31:0] rq1_wdata,
  input  logic [3:0]  rq1_be,
  output logic [31:0] rq1_rdata,
  output logic        rq1_ack,
  output logic        rq1_err,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        tmo_flag,
  output logic        tmo_id,
  input  logic        tmo_clr,
  output logic        gnt_id
);

  arb_state_t       state_q,    state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_id_q,   gnt_id_d;
  arb_req_t         req_q,      req_d;
  logic             reg_cs_q,   reg_cs_d;
  logic [1:0][31:0] rdata_q,    rdata_d;
  logic [1:0]       err_q,      err_d;
  logic [1:0]       ack_q,      ack_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             tmo_id_q,   tmo_id_d;
  logic             pick;
  logic             cnt_clr;
  logic             cnt_en;
  logic             tmo_exp;

  glbl_arb_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk_i     (mclk),
    .rst_ni    (reset_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (tmo_exp)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    req_d      = req_q;
    reg_cs_d   = reg_cs_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ack_d      = '0;
    // A timeout setting the flag on the same edge as tmo_clr overrides the clear.
    tmo_flag_d = tmo_flag_q & ~tmo_clr;
    tmo_id_d   = tmo_id_q;
    pick       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rq0_cs || rq1_cs) begin
          pick       = (rq0_cs && rq1_cs) ? ~last_gnt_q : rq1_cs;
          req_d      = pick ? make_req(rq1_wr, rq1_addr, rq1_wdata, rq1_be)
                            : make_req(rq0_wr, rq0_addr, rq0_wdata, rq0_be);
          reg_cs_d   = 1'b1;
          cnt_clr    = 1'b1;
          last_gnt_d = pick;
          gnt_id_d   = pick;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (reg_ack) begin
          reg_cs_d          = 1'b0;
          rdata_d[gnt_id_q] = reg_rdata;
          err_d[gnt_id_q]   = 1'b0;
          ack_d[gnt_id_q]   = 1'b1;
          state_d           = RESP;
        end else if (tmo_exp) begin
          reg_cs_d          = 1'b0;
          rdata_d[gnt_id_q] = ERR_DATA;
          err_d[gnt_id_q]   = 1'b1;
          ack_d[gnt_id_q]   = 1'b1;
          tmo_flag_d        = 1'b1;
          tmo_id_d          = gnt_id_q;
          state_d           = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        reg_cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      req_q      <= '0;
      reg_cs_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= '0;
      ack_q      <= '0;
      tmo_flag_q <= 1'b0;
      tmo_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      req_q      <= req_d;
      reg_cs_q   <= reg_cs_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_id_q   <= tmo_id_d;
    end
  end

  assign reg_cs    = reg_cs_q;
  assign reg_wr    = req_q.wr;
  assign reg_addr  = req_q.addr;
  assign reg_wdata = req_q.wdata;
  assign reg_be    = req_q.be;
  assign rq0_rdata = rdata_q[0];
  assign rq1_rdata = rdata_q[1];
  assign rq0_err   = err_q[0];
  assign rq1_err   = err_q[1];
  assign rq0_ack   = ack_q[0];
  assign rq1_ack   = ack_q[1];
  assign tmo_flag  = tmo_flag_q;
  assign tmo_id    = tmo_id_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: doc/glbl_reg_arb.md
Name: glbl_reg_arb

Overview:
- Two-master arbiter sharing the single global register bus (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be -> reg_rdata/reg_ack) in front of the global config block.
- Requesters: rq0 is the wishbone host bridge, rq1 is the debug/UART master.
- Round-robin grant, one outstanding access, per-access timeout that returns an error response.

Parameters:
- TMO_CYC, 255: max BUSY cycles waiting for reg_ack before abort; legal range 2..255.
- ERR_DATA, 32'hDEAD_0BAD: read data returned on timeout.

Ports:
- mclk  input  1  clock
- reset_n  input  1  async active-low reset
- rqN_cs  input  1  request, held until rqN_ack (N = 0,1)
- rqN_wr  input  1  1 = write
- rqN_addr  input  8  byte address
- rqN_wdata  input  32  write data
- rqN_be  input  4  byte enables
- rqN_rdata  output  32  read data, valid while rqN_ack = 1
- rqN_ack  output  1  one-cycle completion pulse
- rqN_err  output  1  timeout indication, qualified by rqN_ack
- reg_cs  output  1  target select
- reg_wr  output  1  target write
- reg_addr  output  8  target address
- reg_wdata  output  32  target write data
- reg_be  output  4  target byte enables
- reg_rdata  input  32  target read data
- reg_ack  input  1  target ack
- tmo_flag  output  1  sticky; set on any timeout
- tmo_id  output  1  requester of the last timeout
- tmo_clr  input  1  clears tmo_flag
- gnt_id  output  1  current or last granted requester

Behaviour:
- Clock and reset: one clock, mclk. reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_gnt = 1, so rq0 wins the first tie.
- Registers: all target-side and requester-side outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample rq0_cs and rq1_cs.
  - One requesting: grant it.
  - Both requesting: grant !last_gnt.
  - On grant: latch that requester's wr/addr/wdata/be onto reg_*, set reg_cs = 1, clear the timeout counter, update last_gnt and gnt_id, go to BUSY.
- BUSY:
  - reg_cs held at 1.
  - reg_ack = 1: latch reg_rdata, set reg_cs = 0, go to RESP with err = 0.
  - Otherwise increment the counter.
  - Counter == TMO_CYC-1 with no ack: set reg_cs = 0, rdata = ERR_DATA, err = 1, tmo_flag = 1, tmo_id = granted requester, go to RESP.
  - reg_ack wins over timeout on the same edge.
- RESP:
  - rqN_ack = 1 for exactly one cycle, with rqN_rdata and rqN_err valid, to the granted requester only.
  - Go to IDLE.
- Ack outside BUSY: reg_ack seen in IDLE or RESP (late ack) is ignored.
- Output hold: rdata/err hold their value after ack until the next RESP.
- Latency: request sampled at edge E -> reg_cs high from E. With a target that acks one cycle after cs (reg_ack high in cycle E+1), rqN_ack is high in cycle E+2. Minimum spacing between grants is 3 cycles.
- Requester contract: drop rqN_cs in the cycle after rqN_ack. A request still high in IDLE is treated as new.
- Simultaneous events:
  - tmo_clr and a new timeout on the same edge: set wins.
  - A requester dropping cs while BUSY does not abort the access; the ack is still issued.
- Reset mid-access: reg_cs drops asynchronously, no ack is issued, FSM returns to IDLE.

Decomposition:
- glbl_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t
  - ERR_DATA default constant
  - request struct typedef (wr, addr, wdata, be)
- Sub-module glbl_arb_tmo: 8-bit clearable timeout counter with expiry output.

Test Plan:
- rq0 read addr 0x00 alone, target reset value 0x4433_2211 -> reg_cs 1 cycle after the request is sampled; rq0_ack 2 cycles after reg_cs rises; rq0_rdata = 0x4433_2211, rq0_err = 0.
- rq0 and rq1 both held continuously for 4 accesses after reset -> gnt_id sequence 0,1,0,1; each ack goes only to its owner.
- rq1 write addr 0x04, be = 4'b0010, wdata 0x0000_5500 -> reg_addr 0x04, reg_be 0010, reg_wdata 0x0000_5500; readback gives 0xDDCC_55AA.
- TMO_CYC = 16, target never acks, rq0 read -> rq0_ack after 16 BUSY cycles with rq0_rdata 0xDEAD_0BAD, rq0_err = 1, tmo_flag = 1, tmo_id = 0; tmo_clr -> tmo_flag = 0.
- TMO_CYC = 16, reg_ack in the 16th BUSY cycle -> normal response, err = 0, tmo_flag stays 0.
- reset_n low during BUSY -> reg_cs = 0 immediately, no rqN_ack; after release, rq1 request completes normally.
